tetris_scheduler: RTL and testbench

Central sequencer for the Tetris board datapath. Collects key pulses and a level-scaled gravity tick, arbitrates them into one command stream with a valid/ready handshake to the board-update logic, and gates each move on the move-legality flags. After a piece locks it drives line clearing and the next spawn. It also tracks lines cleared, level and game-over.

---
 rtl/tetris_scheduler_pkg.sv | 41 ++++
 rtl/tetris_scheduler_gravity_timer.sv | 33 +++
 rtl/tetris_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_tetris_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_scheduler_pkg.sv
// Shared op codes, FSM states and request indices for the Tetris scheduler.
// The PAUSE state exists only when TETRIS_PAUSE_EN is defined.
package tetris_scheduler_pkg;

  typedef enum logic [2:0] {
    OP_BOARD_RESET = 3'd0,
    OP_LEFT        = 3'd1,
    OP_RIGHT       = 3'd2,
    OP_DOWN        = 3'd3,
    OP_ROT         = 3'd4,
    OP_LOCK        = 3'd5,
    OP_CLEAR       = 3'd6,
    OP_SPAWN       = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_PLAY,
    ST_CLEAR,
    ST_OVER
`ifdef TETRIS_PAUSE_EN
    , ST_PAUSE
`endif
  } state_e;

  localparam int unsigned N_REQ    = 5;
  localparam int unsigned REQ_LEFT  = 0;
  localparam int unsigned REQ_RIGHT = 1;
  localparam int unsigned REQ_DOWN  = 2;
  localparam int unsigned REQ_ROT   = 3;
  localparam int unsigned REQ_GRAV  = 4;

  localparam logic [2:0] MAX_LEVEL = 3'd7;

  function automatic logic [31:0] grav_period(input logic [31:0] base, input logic [2:0] lvl);
    return base >> lvl;
  endfunction

endpackage

// File: rtl/tetris_scheduler_gravity_timer.sv
// Gravity timer: counts while enabled, period shrinks by 2x per level,
// emits a one-cycle tick on the cycle it wraps.
module gravity_timer
  import tetris_scheduler_pkg::*;
#(
  parameter int unsigned GRAVITY_TICKS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [2:0] level_i,
  output logic       tick_o
);

  logic [31:0] cnt_q;
  logic [31:0] period;

  assign period = grav_period(32'(GRAVITY_TICKS), level_i);
  // >= so a level-up that shortens the period below the current count still ticks
  assign tick_o = en_i & ~clr_i & (cnt_q >= period - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/tetris_scheduler.sv
// Tetris command sequencer: arbitrates keys and gravity into a valid/ready
// command stream, runs lock/clear/spawn, tracks lines, level and game-over.
// Optional pause support is built when TETRIS_PAUSE_EN is defined.
module tetris_scheduler
  import tetris_scheduler_pkg::*;
#(
  parameter int unsigned GRAVITY_TICKS   = 50_000_000,
  parameter int unsigned LINES_PER_LEVEL = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_down,
  input  logic        key_rot,
  input  logic        key_start,
  input  logic        key_pause,
  input  logic        valid_left,
  input  logic        valid_right,
  input  logic        valid_down,
  input  logic        valid_rot,
  input  logic        full_line,
  input  logic        spawn_blocked,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [2:0]  level,
  output logic [15:0] lines_cleared,
  output logic        game_over
);

  state_e           state_q;
  op_e              cmd_op_q, move_op;
  logic             cmd_valid_q, game_over_q;
  logic [2:0]       level_q;
  logic [15:0]      lines_q, sub_q;
  logic [3:0]       key_q;
  logic [N_REQ-1:0] pend_q, pend_d, take;
  logic             pick_down, pick_left, pick_right, pick_rot, move_ok, any_req;
  logic             arb, spawn_go, xfer, grav_tick, tmr_en, tmr_clr, pause_req;

`ifdef TETRIS_PAUSE_EN
  assign pause_req = key_pause & (state_q == ST_PLAY);
`else
  logic unused_pause;
  assign unused_pause = key_pause;
  assign pause_req    = 1'b0;
`endif

  assign xfer    = cmd_valid_q & cmd_ready;
  assign any_req = |pend_q;
  assign tmr_en  = (state_q == ST_PLAY) | (state_q == ST_ISSUE) | (state_q == ST_SETTLE);
  assign tmr_clr = (xfer & (cmd_op_q == OP_DOWN)) | spawn_go;

  always_comb begin
    pick_down  = pend_q[REQ_DOWN] | pend_q[REQ_GRAV];
    pick_left  = ~pick_down & pend_q[REQ_LEFT];
    pick_right = ~pick_down & ~pend_q[REQ_LEFT] & pend_q[REQ_RIGHT];
    pick_rot   = ~pick_down & ~pend_q[REQ_LEFT] & ~pend_q[REQ_RIGHT] & pend_q[REQ_ROT];

    move_op = OP_ROT;
    move_ok = valid_rot;
    if (pick_down) begin
      move_op = valid_down ? OP_DOWN : OP_LOCK;
      move_ok = 1'b1;
    end else if (pick_left) begin
      move_op = OP_LEFT;
      move_ok = valid_left;
    end else if (pick_right) begin
      move_op = OP_RIGHT;
      move_ok = valid_right;
    end

    arb  = (state_q == ST_PLAY) & ~pause_req;
    take = '0;
    if (arb) take = {pick_down, pick_rot, pick_down, pick_right, pick_left};

    spawn_go = (state_q == ST_SETTLE) &
               ((cmd_op_q == OP_BOARD_RESET) |
                (((cmd_op_q == OP_LOCK) | (cmd_op_q == OP_CLEAR)) & ~full_line));

    // set has priority over both consumption and the spawn wipe
    pend_d = pend_q & ~take;
    if (spawn_go) pend_d = '0;
    if ((state_q != ST_IDLE) && (state_q != ST_OVER)) pend_d = pend_d | {grav_tick, key_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_BOARD_RESET;
      level_q     <= '0;
      lines_q     <= '0;
      sub_q       <= '0;
      game_over_q <= 1'b0;
      key_q       <= '0;
      pend_q      <= '0;
    end else begin
      key_q  <= {key_rot, key_down, key_right, key_left};
      pend_q <= pend_d;
      unique case (state_q)
        ST_IDLE: if (key_start) begin
          cmd_valid_q <= 1'b1;
          cmd_op_q    <= OP_BOARD_RESET;
          state_q     <= ST_ISSUE;
        end
        ST_OVER: if (key_start) begin
          lines_q     <= '0;
          level_q     <= '0;
          sub_q       <= '0;
          game_over_q <= 1'b0;
          cmd_valid_q <= 1'b1;
          cmd_op_q    <= OP_BOARD_RESET;
          state_q     <= ST_ISSUE;
        end
        ST_PLAY: begin
          if (pause_req) begin
`ifdef TETRIS_PAUSE_EN
            state_q <= ST_PAUSE;
`endif
          end else if (any_req && move_ok) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= move_op;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: if (cmd_ready) begin
          cmd_valid_q <= 1'b0;
          state_q     <= ST_SETTLE;
          if (cmd_op_q == OP_CLEAR) begin
            if (lines_q != '1) lines_q <= lines_q + 16'd1;
            if (sub_q == 16'(LINES_PER_LEVEL - 1)) begin
              sub_q <= '0;
              if (level_q != MAX_LEVEL) level_q <= level_q + 3'd1;
            end else begin
              sub_q <= sub_q + 16'd1;
            end
          end
        end
        ST_SETTLE: begin
          if (spawn_go) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_SPAWN;
            state_q     <= ST_ISSUE;
          end else if ((cmd_op_q == OP_LOCK) || (cmd_op_q == OP_CLEAR)) begin
            state_q <= ST_CLEAR;
          end else if ((cmd_op_q == OP_SPAWN) && spawn_blocked) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
          end else begin
            state_q <= ST_PLAY;
          end
        end
        ST_CLEAR: begin
          cmd_valid_q <= 1'b1;
          cmd_op_q    <= OP_CLEAR;
          state_q     <= ST_ISSUE;
        end
`ifdef TETRIS_PAUSE_EN
        ST_PAUSE: if (key_pause) state_q <= ST_PLAY;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  gravity_timer #(
    .GRAVITY_TICKS(GRAVITY_TICKS)
  ) u_gravity_timer (
    .clk     (clk),
    .rst     (rst),
    .en_i    (tmr_en),
    .clr_i   (tmr_clr),
    .level_i (level_q),
    .tick_o  (grav_tick)
  );

  assign cmd_valid     = cmd_valid_q;
  assign cmd_op        = cmd_op_q;
  assign level         = level_q;
  assign lines_cleared = lines_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_tetris_scheduler.sv
// Scoreboard bench for tetris_scheduler: stimulus pushes expected ops,
// a monitor pops and compares on every accepted command.
module tb_tetris_scheduler;

  localparam logic [2:0] B_RESET = 3'd0, B_LEFT = 3'd1, B_RIGHT = 3'd2, B_DOWN = 3'd3,
                         B_ROT = 3'd4, B_LOCK = 3'd5, B_CLEAR = 3'd6, B_SPAWN = 3'd7;
  localparam int G_TICKS = 256;

  logic clk = 1'b0, rst = 1'b0;
  logic key_left = 0, key_right = 0, key_down = 0, key_rot = 0, key_start = 0, key_pause = 0;
  logic valid_left = 1, valid_right = 1, valid_down = 1, valid_rot = 1;
  logic full_line, spawn_blocked = 0, cmd_ready = 1;
  logic cmd_valid, game_over;
  logic [2:0] cmd_op, level;
  logic [15:0] lines_cleared;

  int vectors = 0, miscompares = 0;
  int cyc = 0, xfer_cnt = 0, xfer_cyc = 0, rows_left = 0, ready_mode = 0;
  logic [2:0] exp_q[$];
  int m_lines = 0, m_level = 0, m_sub = 0;

  assign full_line = (rows_left != 0);

  tetris_scheduler #(.GRAVITY_TICKS(G_TICKS), .LINES_PER_LEVEL(10)) dut (
    .clk(clk), .rst(rst),
    .key_left(key_left), .key_right(key_right), .key_down(key_down), .key_rot(key_rot),
    .key_start(key_start), .key_pause(key_pause),
    .valid_left(valid_left), .valid_right(valid_right), .valid_down(valid_down), .valid_rot(valid_rot),
    .full_line(full_line), .spawn_blocked(spawn_blocked), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .level(level),
    .lines_cleared(lines_cleared), .game_over(game_over)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (ready_mode == 0) cmd_ready = 1'b1;
    else if (ready_mode == 1) cmd_ready = ($urandom_range(0, 2) != 0);
    else cmd_ready = 1'b0;
  end

  // monitor: samples just before each rising edge
  initial begin
    logic stall;
    logic [2:0] stall_op, e;
    stall = 0;
    stall_op = '0;
    forever begin
      @(negedge clk); #4;
      if (!rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          vectors++;
          if (!(cmd_valid && cmd_op == stall_op)) begin
            miscompares++;
            $display("FAIL hold: valid=%0b op=%0d, required valid=1 op=%0d", cmd_valid, cmd_op, stall_op);
          end
        end
        if (cmd_valid && cmd_ready) begin
          xfer_cnt++;
          xfer_cyc = cyc;
          if (cmd_op == B_CLEAR && rows_left > 0) rows_left--;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL cmd: op=%0d accepted, required none", cmd_op);
          end else begin
            e = exp_q.pop_front();
            if (e != cmd_op) begin
              miscompares++;
              $display("FAIL cmd: op=%0d, required %0d", cmd_op, e);
            end
          end
        end
        stall = cmd_valid && !cmd_ready;
        stall_op = cmd_op;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic pulse(input bit kl, input bit kr, input bit kd, input bit kt, input bit ks);
    @(negedge clk);
    key_left = kl; key_right = kr; key_down = kd; key_rot = kt; key_start = ks;
    @(negedge clk);
    key_left = 0; key_right = 0; key_down = 0; key_rot = 0; key_start = 0;
  endtask

  task automatic wait_idle();
    int idle;
    idle = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !cmd_valid) idle++; else idle = 0;
      if (idle >= 8) return;
    end
    check("drain timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_xfer(input int target, output int t);
    t = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (xfer_cnt >= target) begin t = xfer_cyc; return; end
    end
    check("xfer timeout", xfer_cnt, target);
  endtask

  // Reference: resolve a set of simultaneous requests by priority, legality and lock rules.
  task automatic predict_moves(input bit kl, input bit kr, input bit kd, input bit kt,
                               input bit vl, input bit vr, input bit vd, input bit vt);
    bit pl, pr, pd, pt;
    pl = kl; pr = kr; pd = kd; pt = kt;
    while (pl || pr || pd || pt) begin
      if (pd) begin
        pd = 0;
        if (vd) exp_q.push_back(B_DOWN);
        else begin
          exp_q.push_back(B_LOCK);
          exp_q.push_back(B_SPAWN);
          pl = 0; pr = 0; pt = 0;
        end
      end else if (pl) begin
        pl = 0;
        if (vl) exp_q.push_back(B_LEFT);
      end else if (pr) begin
        pr = 0;
        if (vr) exp_q.push_back(B_RIGHT);
      end else begin
        pt = 0;
        if (vt) exp_q.push_back(B_ROT);
      end
    end
  endtask

  task automatic model_clear();
    if (m_lines < 65535) m_lines++;
    m_sub++;
    if (m_sub == 10) begin
      m_sub = 0;
      if (m_level < 7) m_level++;
    end
  endtask

  task automatic start_game();
    exp_q.push_back(B_RESET);
    exp_q.push_back(B_SPAWN);
    pulse(0, 0, 0, 0, 1);
    wait_idle();
  endtask

  task automatic gravity_gap(input string name);
    int base, t0, t1, t2;
    for (int k = 0; k < 3; k++) exp_q.push_back(B_DOWN);
    base = xfer_cnt;
    wait_xfer(base + 1, t0);
    wait_xfer(base + 2, t1);
    wait_xfer(base + 3, t2);
    // accepted DOWN restarts the timer; +1 cycle to arbitrate, +1 to accept
    check(name, t1 - t0, (G_TICKS >> m_level) + 2);
    check(name, t2 - t1, (G_TICKS >> m_level) + 2);
    wait_idle();
  endtask

  initial begin
    int lat, t;
    bit kl, kr, kd, kt, vl, vr, vd, vt;

    // reset values
    #23;
    check("rst cmd_valid", cmd_valid, 0);
    check("rst cmd_op", cmd_op, 0);
    check("rst level", level, 0);
    check("rst lines", lines_cleared, 0);
    check("rst game_over", game_over, 0);
    @(negedge clk); rst = 1;

    // moves ignored in IDLE, then start
    pulse(1, 1, 1, 1, 0);
    wait_idle();
    start_game();
    check("start level", level, 0);
    check("start lines", lines_cleared, 0);
    check("start game_over", game_over, 0);

    // priority LEFT over ROT and pulse-to-valid latency
    exp_q.push_back(B_LEFT);
    exp_q.push_back(B_ROT);
    @(negedge clk); key_left = 1; key_rot = 1;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      key_left = 0; key_rot = 0;
      if (cmd_valid) begin lat = k; break; end
    end
    check("latency", lat, 2);
    wait_idle();

    // illegal move dropped, later legal one issued
    valid_right = 0;
    pulse(0, 1, 0, 0, 0);
    wait_idle();
    valid_right = 1;
    exp_q.push_back(B_RIGHT);
    pulse(0, 1, 0, 0, 0);
    wait_idle();

    gravity_gap("gravity L0");

    // backpressure: op held, down during stall retained
    ready_mode = 2;
    exp_q.push_back(B_LEFT);
    exp_q.push_back(B_DOWN);
    pulse(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !cmd_valid; i++) @(negedge clk);
    pulse(0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("stall valid", cmd_valid, 1);
    check("stall op", cmd_op, B_LEFT);
    ready_mode = 0;
    wait_idle();

    // randomized moves with random backpressure and legality
    ready_mode = 1;
    for (int i = 0; i < 30; i++) begin
      kl = 1'($urandom_range(0, 1)); kr = 1'($urandom_range(0, 1));
      kt = 1'($urandom_range(0, 1));
      kd = (i % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      vl = 1'($urandom_range(0, 1)); vr = 1'($urandom_range(0, 1));
      vt = 1'($urandom_range(0, 1)); vd = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      valid_left = vl; valid_right = vr; valid_down = vd; valid_rot = vt;
      predict_moves(kl, kr, kd, kt, vl, vr, vd, vt);
      pulse(kl, kr, kd, kt, 1'($urandom_range(0, 1)));
      wait_idle();
    end
    check("rand game_over", game_over, 0);
    ready_mode = 0;

    // lock with two full rows, five times -> 10 lines, level 1
    valid_left = 1; valid_right = 1; valid_rot = 1;
    for (int r = 0; r < 5; r++) begin
      valid_down = 0;
      rows_left = 2;
      exp_q.push_back(B_LOCK);
      exp_q.push_back(B_CLEAR);
      exp_q.push_back(B_CLEAR);
      exp_q.push_back(B_SPAWN);
      model_clear(); model_clear();
      pulse(0, 0, 1, 0, 0);
      wait_idle();
      check("clear lines", lines_cleared, m_lines);
      check("clear level", level, m_level);
    end
    valid_down = 1;
    gravity_gap("gravity L1");

    // game over, commands suppressed, restart
    spawn_blocked = 1;
    valid_down = 0;
    exp_q.push_back(B_LOCK);
    exp_q.push_back(B_SPAWN);
    pulse(0, 0, 1, 0, 0);
    wait_idle();
    check("over flag", game_over, 1);
    valid_down = 1;
    pulse(1, 1, 1, 1, 0);
    repeat (300) @(negedge clk);
    check("over no cmd", exp_q.size(), 0);
    spawn_blocked = 0;
    m_lines = 0; m_level = 0; m_sub = 0;
    start_game();
    check("restart game_over", game_over, 0);
    check("restart lines", lines_cleared, m_lines);
    check("restart level", level, m_level);

    // reset during a stalled handshake
    ready_mode = 2;
    exp_q.push_back(B_LEFT);
    pulse(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !cmd_valid; i++) @(negedge clk);
    check("pre-rst valid", cmd_valid, 1);
    #2 rst = 0;
    #1 check("async rst valid", cmd_valid, 0);
    exp_q.delete();
    @(negedge clk); rst = 1;
    ready_mode = 0;
    start_game();

    wait_xfer(0, t);
    check("leftover expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
